// File: rtl/decoder_2to4_3to8_pkg.sv
// Shared widths for the paired 2:4 / 3:8 write-enable decoders.
`timescale 1ps/1ps
package decoder_2to4_3to8_pkg;

    // Select-code widths of the two decoders.
    localparam int DEC2_W = 2;
    localparam int DEC3_W = 3;

    // One-hot output widths follow directly from the select widths.
    localparam int DEC2_N = 1 << DEC2_W;
    localparam int DEC3_N = 1 << DEC3_W;

endpackage

// File: rtl/decoder_2to4_3to8_if.sv
// Bundle of decoder selects, enables and one-hot outputs.
// master drives selects/enables; slave (the decoder) drives the outputs.
`timescale 1ps/1ps
interface decoder_2to4_3to8_if;
    import decoder_2to4_3to8_pkg::*;

    logic              RegWrite;
    logic [DEC2_W-1:0] select;
    logic [DEC2_N-1:0] enabler;
    logic              enable;
    logic [DEC3_W-1:0] selectbits;
    logic [DEC3_N-1:0] enable_reg;

    modport master (
        output RegWrite,
        output select,
        output enable,
        output selectbits,
        input  enabler,
        input  enable_reg
    );

    modport slave (
        input  RegWrite,
        input  select,
        input  enable,
        input  selectbits,
        output enabler,
        output enable_reg
    );

endinterface

// File: rtl/decoder_2to4_3to8_decode_and_gate.sv
// Four-input AND used as the product term of both decoders.
// Callers needing fewer inputs tie the spare ones high.
`timescale 1ps/1ps
module decoder_2to4_3to8_decode_and_gate #(
    parameter int GATE_DELAY = 50
) (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    and #(GATE_DELAY) uAnd4 (y, a, b, c, d);

endmodule

// File: rtl/decoder_2to4_3to8.sv
// Paired enable-gated 2:4 and 3:8 decoders for the register-file
// write-enable path. Decode is built from primitive gates (inverter then a
// single AND that also carries the enable); outputs are either registered
// with an asynchronous clear, or passed through a reset AND when unregistered.
`timescale 1ps/1ps
module decoder_2to4_3to8
    import decoder_2to4_3to8_pkg::*;
#(
    parameter int GATE_DELAY = 50,
    parameter bit REG_OUT    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    decoder_2to4_3to8_if.slave    bus
);

    logic [DEC2_W-1:0] selectN;
    logic [DEC3_W-1:0] selectbitsN;
    logic [DEC2_N-1:0] dec2;
    logic [DEC3_N-1:0] dec3;
    logic [DEC2_N-1:0] enablerOut;
    logic [DEC3_N-1:0] enableRegOut;

    // Complemented select lines, one inverter per bit.
    for (genvar b = 0; b < DEC2_W; b++) begin : gInv2
        not #(GATE_DELAY) uNot (selectN[b], bus.select[b]);
    end

    for (genvar b = 0; b < DEC3_W; b++) begin : gInv3
        not #(GATE_DELAY) uNot (selectbitsN[b], bus.selectbits[b]);
    end

    // 2:4 product terms: enable, s1 term, s0 term; fourth input tied high.
    for (genvar i = 0; i < DEC2_N; i++) begin : gDec2
        localparam logic [DEC2_W-1:0] CODE = DEC2_W'(i);
        decoder_2to4_3to8_decode_and_gate #(
            .GATE_DELAY (GATE_DELAY)
        ) uTerm (
            .a (bus.RegWrite),
            .b (CODE[1] ? bus.select[1] : selectN[1]),
            .c (CODE[0] ? bus.select[0] : selectN[0]),
            .d (1'b1),
            .y (dec2[i])
        );
    end

    // 3:8 product terms: enable, s2 term, s1 term, s0 term.
    for (genvar i = 0; i < DEC3_N; i++) begin : gDec3
        localparam logic [DEC3_W-1:0] CODE = DEC3_W'(i);
        decoder_2to4_3to8_decode_and_gate #(
            .GATE_DELAY (GATE_DELAY)
        ) uTerm (
            .a (bus.enable),
            .b (CODE[2] ? bus.selectbits[2] : selectbitsN[2]),
            .c (CODE[1] ? bus.selectbits[1] : selectbitsN[1]),
            .d (CODE[0] ? bus.selectbits[0] : selectbitsN[0]),
            .y (dec3[i])
        );
    end

    if (REG_OUT) begin : gReg
        logic [DEC2_N-1:0] enabler_p0;
        logic [DEC3_N-1:0] enableReg_p0;

        // Output register bank: clears immediately on reset, loads decode each edge.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                enabler_p0   <= '0;
                enableReg_p0 <= '0;
            end else begin
                enabler_p0   <= dec2;
                enableReg_p0 <= dec3;
            end
        end

        assign enablerOut   = enabler_p0;
        assign enableRegOut = enableReg_p0;
    end else begin : gComb
        // Unregistered outputs are still forced low by reset through one AND level.
        for (genvar i = 0; i < DEC2_N; i++) begin : gRst2
            and #(GATE_DELAY) uRstAnd (enablerOut[i], dec2[i], reset_n);
        end

        for (genvar i = 0; i < DEC3_N; i++) begin : gRst3
            and #(GATE_DELAY) uRstAnd (enableRegOut[i], dec3[i], reset_n);
        end
    end

    assign bus.enabler    = enablerOut;
    assign bus.enable_reg = enableRegOut;

    // Each decoder output carries at most one active write enable.
    assert property (@(posedge clk) $onehot0(enablerOut));
    assert property (@(posedge clk) $onehot0(enableRegOut));

endmodule

// File: tb/tb_decoder_2to4_3to8.sv
// Bench for decoder_2to4_3to8: a registered instance driven by directed
// vectors, plus four unregistered instances cascaded off its 2:4 output to
// form a 5:32 decoder. Expected responses are queued by the driver and
// popped by an independent monitor shortly after each rising edge.
`timescale 1ps/1ps
module tb_decoder_2to4_3to8;

    localparam int CLK_HALF = 5000;

    typedef struct {
        logic [3:0]  en;
        logic [7:0]  regExp;
        logic        chkCas;
        logic [31:0] cas;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] casOut;
    int          checks   = 0;
    int          failures = 0;
    exp_t        expQ[$];

    decoder_2to4_3to8_if bus ();

    decoder_2to4_3to8 #(
        .GATE_DELAY (50),
        .REG_OUT    (1'b1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 5:32 cascade: registered 2:4 output enables four combinational 3:8s.
    for (genvar k = 0; k < 4; k++) begin : gCas
        decoder_2to4_3to8_if cbus ();
        assign cbus.RegWrite   = 1'b0;
        assign cbus.select     = 2'b00;
        assign cbus.enable     = bus.enabler[k];
        assign cbus.selectbits = bus.selectbits;
        decoder_2to4_3to8 #(
            .GATE_DELAY (50),
            .REG_OUT    (1'b0)
        ) uCas (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (cbus)
        );
        assign casOut[k*8 +: 8] = cbus.enable_reg;
    end

    always #CLK_HALF clk = ~clk;

    task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", tag, act, req);
        end
    endtask

    task automatic pushExp(input logic [3:0] xEn, input logic [7:0] xReg,
                           input logic chk, input logic [31:0] xCas, input string tag);
        exp_t e;
        e.en     = xEn;
        e.regExp = xReg;
        e.chkCas = chk;
        e.cas    = xCas;
        e.tag    = tag;
        expQ.push_back(e);
    endtask

    // Apply one vector just after a rising edge; its result is due at the next edge.
    task automatic step(input logic rw, input logic [1:0] sel, input logic en,
                        input logic [2:0] sb, input logic [3:0] xEn, input logic [7:0] xReg,
                        input logic chk, input logic [31:0] xCas, input string tag);
        @(posedge clk);
        #1000;
        bus.RegWrite   = rw;
        bus.select     = sel;
        bus.enable     = en;
        bus.selectbits = sb;
        pushExp(xEn, xReg, chk, xCas, tag);
    endtask

    // Monitor: pop and compare one expectation after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #500;
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                cmp({e.tag, ".enabler"}, 32'(bus.enabler), 32'(e.en));
                cmp({e.tag, ".enable_reg"}, 32'(bus.enable_reg), 32'(e.regExp));
                cmp({e.tag, ".onehot0"},
                    32'($onehot0(bus.enabler) && $onehot0(bus.enable_reg)), 32'd1);
                if (e.regExp != 8'h00)
                    cmp({e.tag, ".onehot3"}, 32'($onehot(bus.enable_reg)), 32'd1);
                if (e.chkCas)
                    cmp({e.tag, ".cascade"}, casOut, e.cas);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] exp2 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] exp3 [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // Directed stimulus.
    initial begin
        reset_n        = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.select     = 2'b00;
        bus.enable     = 1'b0;
        bus.selectbits = 3'b000;

        // Reset state before any clock edge.
        #200;
        cmp("rst_init.enabler", 32'(bus.enabler), 32'h0);
        cmp("rst_init.enable_reg", 32'(bus.enable_reg), 32'h0);

        repeat (2) @(posedge clk);
        #1000;
        reset_n = 1'b1;

        // Load non-zero outputs, then clear them asynchronously mid-cycle.
        step(1'b1, 2'b11, 1'b1, 3'b111, 4'b1000, 8'h80, 1'b0, 32'h0, "pre_rst");
        @(posedge clk);
        #5000;
        reset_n = 1'b0;
        #200;
        cmp("rst_async.enabler", 32'(bus.enabler), 32'h0);
        cmp("rst_async.enable_reg", 32'(bus.enable_reg), 32'h0);
        @(posedge clk);
        #1000;
        cmp("rst_hold.enabler", 32'(bus.enabler), 32'h0);
        cmp("rst_hold.enable_reg", 32'(bus.enable_reg), 32'h0);
        reset_n = 1'b1;
        pushExp(4'b1000, 8'h80, 1'b0, 32'h0, "rst_release");

        // Both enables low across every select code.
        for (int i = 0; i < 8; i++)
            step(1'b0, 2'(i), 1'b0, 3'(i), 4'b0000, 8'h00, 1'b0, 32'h0, "en_low");

        // 2:4 exhaustive.
        for (int i = 0; i < 4; i++)
            step(1'b1, 2'(i), 1'b0, 3'b000, exp2[i], 8'h00, 1'b0, 32'h0, "dec2");

        // 3:8 exhaustive.
        for (int i = 0; i < 8; i++)
            step(1'b0, 2'b00, 1'b1, 3'(i), 4'b0000, exp3[i], 1'b0, 32'h0, "dec3");

        // Enable drop together with a select change goes straight to zero.
        step(1'b1, 2'b01, 1'b1, 3'b101, 4'b0010, 8'h20, 1'b0, 32'h0, "pre_drop");
        step(1'b0, 2'b10, 1'b0, 3'b010, 4'b0000, 8'h00, 1'b0, 32'h0, "en_drop");

        // 5:32 cascade, code = {select, selectbits}.
        step(1'b1, 2'b00, 1'b1, 3'b000, 4'b0001, 8'h01, 1'b1, 32'h0000_0001, "cas_00000");
        step(1'b1, 2'b11, 1'b1, 3'b111, 4'b1000, 8'h80, 1'b1, 32'h8000_0000, "cas_11111");
        step(1'b1, 2'b11, 1'b1, 3'b110, 4'b1000, 8'h40, 1'b1, 32'h4000_0000, "cas_11110");
        step(1'b1, 2'b10, 1'b1, 3'b101, 4'b0100, 8'h20, 1'b1, 32'h0020_0000, "cas_10101");
        step(1'b0, 2'b00, 1'b1, 3'b000, 4'b0000, 8'h01, 1'b1, 32'h0, "cas_off_00000");
        step(1'b0, 2'b11, 1'b1, 3'b111, 4'b0000, 8'h80, 1'b1, 32'h0, "cas_off_11111");
        step(1'b0, 2'b11, 1'b1, 3'b110, 4'b0000, 8'h40, 1'b1, 32'h0, "cas_off_11110");
        step(1'b0, 2'b10, 1'b1, 3'b101, 4'b0000, 8'h20, 1'b1, 32'h0, "cas_off_10101");

        // Toggle RegWrite with everything else held.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                step(1'b1, 2'b10, 1'b1, 3'b101, 4'b0100, 8'h20, 1'b0, 32'h0, "toggle_on");
            else
                step(1'b0, 2'b10, 1'b1, 3'b101, 4'b0000, 8'h20, 1'b0, 32'h0, "toggle_off");
        end

        // Drain outstanding expectations within a bounded number of cycles.
        for (int t = 0; t < 10 && expQ.size() > 0; t++)
            @(posedge clk);
        #2000;
        cmp("drain.pending", 32'(expQ.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
